// File: rtl/trig_arbiter.sv
// Round-robin arbiter sharing one trig unit (1-cycle LUT) among N_REQ requesters.
// A grant is withheld when it would change trig_iscos under an op still reading the unit.
module trig_arbiter #(
   parameter int N_REQ = 4,
   parameter int ID_W  = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [N_REQ-1:0]    req_valid,
   output logic [N_REQ-1:0]    req_ready,
   input  logic [12*N_REQ-1:0] req_degree,
   input  logic [N_REQ-1:0]    req_iscos,
   output logic [11:0]         trig_degree,
   output logic                trig_iscos,
   input  logic [9:0]          trig_value,
   output logic                rsp_valid,
   output logic [ID_W-1:0]     rsp_id,
   output logic [9:0]          rsp_value,
   output logic                rsp_iscos
);

   logic [ID_W-1:0] ptr_q, ptr_d;
   logic            iss_vld_q, iss_vld_d;
   logic [11:0]     iss_deg_q, iss_deg_d;
   logic            iss_iscos_q, iss_iscos_d;
   logic [ID_W-1:0] iss_id_q, iss_id_d;
   logic            res_vld_q;
   logic [ID_W-1:0] res_id_q;
   logic            res_iscos_q;
   logic            rsp_vld_q;
   logic [ID_W-1:0] rsp_id_q;
   logic [9:0]      rsp_val_q;
   logic            rsp_iscos_q;

   logic            cand_found;
   logic [ID_W-1:0] cand_id;
   logic [11:0]     cand_deg;
   logic            grant;

   function automatic logic [ID_W-1:0] rr_idx(input logic [ID_W-1:0] base, input int off);
      int s;
      s = int'(base) + off;
      if (s >= N_REQ) s = s - N_REQ;
      return ID_W'(s);
   endfunction

   // Scan from the highest offset down so the closest valid requester to ptr wins.
   always_comb begin
      cand_found = 1'b0;
      cand_id    = '0;
      for (int off = N_REQ-1; off >= 0; off--) begin
         if (req_valid[rr_idx(ptr_q, off)]) begin
            cand_found = 1'b1;
            cand_id    = rr_idx(ptr_q, off);
         end
      end
   end

   assign cand_deg = req_degree[int'(cand_id)*12 +: 12];
   assign grant    = rst && cand_found &&
                     (!iss_vld_q || (req_iscos[cand_id] == iss_iscos_q));

   always_comb begin
      req_ready = '0;
      if (grant) req_ready[cand_id] = 1'b1;
   end

   // Degree and iscos hold while ISS is empty so the unit input never glitches.
   always_comb begin
      ptr_d       = ptr_q;
      iss_vld_d   = 1'b0;
      iss_deg_d   = iss_deg_q;
      iss_iscos_d = iss_iscos_q;
      iss_id_d    = iss_id_q;
      if (grant) begin
         ptr_d       = rr_idx(cand_id, 1);
         iss_vld_d   = 1'b1;
         iss_deg_d   = (cand_deg >= 12'd3600) ? cand_deg - 12'd3600 : cand_deg;
         iss_iscos_d = req_iscos[cand_id];
         iss_id_d    = cand_id;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr_q       <= '0;
         iss_vld_q   <= 1'b0;
         iss_deg_q   <= '0;
         iss_iscos_q <= 1'b0;
         iss_id_q    <= '0;
         res_vld_q   <= 1'b0;
         res_id_q    <= '0;
         res_iscos_q <= 1'b0;
         rsp_vld_q   <= 1'b0;
         rsp_id_q    <= '0;
         rsp_val_q   <= '0;
         rsp_iscos_q <= 1'b0;
      end else begin
         ptr_q       <= ptr_d;
         iss_vld_q   <= iss_vld_d;
         iss_deg_q   <= iss_deg_d;
         iss_iscos_q <= iss_iscos_d;
         iss_id_q    <= iss_id_d;
         res_vld_q   <= iss_vld_q;
         res_id_q    <= iss_id_q;
         res_iscos_q <= iss_iscos_q;
         rsp_vld_q   <= res_vld_q;
         if (res_vld_q) begin
            rsp_id_q    <= res_id_q;
            rsp_val_q   <= trig_value;
            rsp_iscos_q <= res_iscos_q;
         end
      end
   end

   assign trig_degree = iss_deg_q;
   assign trig_iscos  = iss_iscos_q;
   assign rsp_valid   = rsp_vld_q;
   assign rsp_id      = rsp_id_q;
   assign rsp_value   = rsp_val_q;
   assign rsp_iscos   = rsp_iscos_q;

endmodule

// File: tb/tb_trig_arbiter.sv
// Directed bench for trig_arbiter with a registered sin/cos LUT model as the trig unit.
module tb_trig_arbiter;
   localparam int N_REQ = 4;
   localparam int ID_W  = 2;

   logic                clk = 1'b0;
   logic                rst;
   logic [N_REQ-1:0]    req_valid;
   logic [N_REQ-1:0]    req_ready;
   logic [12*N_REQ-1:0] req_degree;
   logic [N_REQ-1:0]    req_iscos;
   logic [11:0]         trig_degree;
   logic                trig_iscos;
   logic [9:0]          trig_value;
   logic                rsp_valid;
   logic [ID_W-1:0]     rsp_id;
   logic [9:0]          rsp_value;
   logic                rsp_iscos;

   int n_chk  = 0;
   int n_fail = 0;

   trig_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_degree(req_degree), .req_iscos(req_iscos),
      .trig_degree(trig_degree), .trig_iscos(trig_iscos), .trig_value(trig_value),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_value(rsp_value), .rsp_iscos(rsp_iscos)
   );

   always #5 clk = ~clk;

   function automatic real unit_f(input int deg, input bit c);
      real a;
      a = deg * 3.141592653589793 / 1800.0;
      return 511.0 * (c ? $cos(a) : $sin(a));
   endfunction

   function automatic int golden(input int deg, input bit c);
      real v;
      v = unit_f(deg, c);
      return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
   endfunction

   // Trig unit: LUT registered on degree, iscos mux applied combinationally.
   logic signed [9:0] sin_q, cos_q;
   always @(posedge clk) begin
      sin_q <= 10'($rtoi(unit_f(int'(trig_degree), 1'b0)));
      cos_q <= 10'($rtoi(unit_f(int'(trig_degree), 1'b1)));
   end
   assign trig_value = trig_iscos ? cos_q : sin_q;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic chk_val(input string nm, input int exp);
      int act;
      act = int'($signed(rsp_value));
      n_chk++;
      if (act - exp > 1 || exp - act > 1) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d +-1", nm, act, exp);
      end
   endtask

   task automatic set_req(input int r, input int deg, input bit c);
      req_degree[12*r +: 12] = 12'(deg);
      req_iscos[r]           = c;
   endtask

   task automatic do_reset();
      req_valid = '0;
      rst = 1'b0;
      tick();
      rst = 1'b1;
   endtask

   task automatic run_single(input int r, input int deg, input bit c, input int exp_deg);
      req_valid = '0;
      set_req(r, deg, c);
      req_valid[r] = 1'b1;
      #1 chk("single_ready", 32'(req_ready), 32'(1 << r));
      tick();
      req_valid = '0;
      chk("single_trig_deg", 32'(trig_degree), 32'(exp_deg));
      chk("single_trig_iscos", 32'(trig_iscos), 32'(c));
      chk("single_rsp_early0", 32'(rsp_valid), 0);
      tick();
      chk("single_rsp_early1", 32'(rsp_valid), 0);
      tick();
      chk("single_rsp_valid", 32'(rsp_valid), 1);
      chk("single_rsp_id", 32'(rsp_id), 32'(r));
      chk("single_rsp_iscos", 32'(rsp_iscos), 32'(c));
      chk_val("single_rsp_value", golden(exp_deg, c));
      tick();
      chk("single_rsp_pulse", 32'(rsp_valid), 0);
   endtask

   typedef struct {
      int r;
      int deg;
      bit c;
      int exp_deg;
   } vec_t;

   vec_t vt[7];

   initial begin
      vt[0] = '{0,  900, 1'b0,  900};
      vt[1] = '{2, 4000, 1'b1,  400};
      vt[2] = '{1, 3599, 1'b0, 3599};
      vt[3] = '{3, 3600, 1'b1,    0};
      vt[4] = '{2, 4095, 1'b0,  495};
      vt[5] = '{1, 1800, 1'b1, 1800};
      vt[6] = '{3,  450, 1'b0,  450};

      rst        = 1'b0;
      req_valid  = '0;
      req_degree = '0;
      req_iscos  = '0;
      #1;
      req_valid = '1;
      #1;
      chk("rst_ready", 32'(req_ready), 0);
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_trig_deg", 32'(trig_degree), 0);
      req_valid = '0;
      tick();
      rst = 1'b1;

      for (int i = 0; i < 7; i++)
         run_single(vt[i].r, vt[i].deg, vt[i].c, vt[i].exp_deg);

      // All four sine requesters held: one grant per cycle, no rsp gaps.
      do_reset();
      for (int i = 0; i < N_REQ; i++) set_req(i, 100*(i+1), 1'b0);
      req_valid = '1;
      for (int cyc = 0; cyc < 10; cyc++) begin
         if (cyc >= 8) req_valid = '0;
         #1 chk("rr_ready", 32'(req_ready), (cyc < 8) ? 32'(1 << (cyc % 4)) : 0);
         tick();
         if (cyc >= 2) begin
            chk("rr_rsp_valid", 32'(rsp_valid), 1);
            chk("rr_rsp_id", 32'(rsp_id), 32'((cyc-2) % 4));
            chk_val("rr_rsp_value", golden(100*(((cyc-2) % 4)+1), 1'b0));
         end
      end
      tick();
      chk("rr_rsp_done", 32'(rsp_valid), 0);

      // Sine then cosine: bubble before the iscos switch.
      do_reset();
      set_req(0, 300, 1'b0);
      set_req(1, 600, 1'b1);
      req_valid = 4'b0011;
      #1 chk("mix_ready0", 32'(req_ready), 32'b0001);
      tick();
      req_valid = 4'b0010;
      #1 chk("mix_bubble", 32'(req_ready), 0);
      chk("mix_iscos_a", 32'(trig_iscos), 0);
      tick();
      chk("mix_iscos_b", 32'(trig_iscos), 0);
      chk("mix_ready1", 32'(req_ready), 32'b0010);
      tick();
      req_valid = '0;
      chk("mix_rsp0_valid", 32'(rsp_valid), 1);
      chk("mix_rsp0_id", 32'(rsp_id), 0);
      chk("mix_rsp0_iscos", 32'(rsp_iscos), 0);
      chk_val("mix_rsp0_value", golden(300, 1'b0));
      chk("mix_iscos_c", 32'(trig_iscos), 1);
      tick();
      chk("mix_gap", 32'(rsp_valid), 0);
      tick();
      chk("mix_rsp1_valid", 32'(rsp_valid), 1);
      chk("mix_rsp1_id", 32'(rsp_id), 1);
      chk_val("mix_rsp1_value", golden(600, 1'b1));

      // Reset with ops in ISS, RES and RSP.
      do_reset();
      for (int i = 0; i < 3; i++) set_req(i, 100*(i+1), 1'b1);
      req_valid = 4'b0111;
      tick(); tick(); tick();
      chk("rst_pre_rsp", 32'(rsp_valid), 1);
      chk("rst_pre_deg", 32'(trig_degree), 300);
      req_valid = '1;
      rst = 1'b0;
      #1;
      chk("rstm_ready", 32'(req_ready), 0);
      chk("rstm_rsp_valid", 32'(rsp_valid), 0);
      chk("rstm_rsp_value", 32'(rsp_value), 0);
      chk("rstm_rsp_iscos", 32'(rsp_iscos), 0);
      chk("rstm_trig_deg", 32'(trig_degree), 0);
      chk("rstm_trig_iscos", 32'(trig_iscos), 0);
      req_valid = '0;
      tick();
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rstm_no_rsp", 32'(rsp_valid), 0);
      end
      run_single(2, 450, 1'b1, 450);

      // Req3 cosine streaming, req0 sine waits at most one bubble.
      do_reset();
      set_req(3, 200, 1'b1);
      set_req(0, 700, 1'b0);
      req_valid = 4'b1000;
      #1 chk("str_ready_c0", 32'(req_ready), 32'b1000);
      tick();
      chk("str_rsp_c0", 32'(rsp_valid), 0);
      req_valid = 4'b1001;
      #1 chk("str_bubble_c1", 32'(req_ready), 0);
      tick();
      chk("str_rsp_c1", 32'(rsp_valid), 0);
      #1 chk("str_ready_c2", 32'(req_ready), 32'b0001);
      tick();
      req_valid = 4'b1000;
      chk("str_rsp_c2", 32'(rsp_valid), 1);
      chk("str_rsp_c2_id", 32'(rsp_id), 3);
      chk_val("str_rsp_c2_value", golden(200, 1'b1));
      #1 chk("str_bubble_c3", 32'(req_ready), 0);
      tick();
      chk("str_rsp_c3", 32'(rsp_valid), 0);
      #1 chk("str_ready_c4", 32'(req_ready), 32'b1000);
      tick();
      req_valid = '0;
      chk("str_rsp_c4", 32'(rsp_valid), 1);
      chk("str_rsp_c4_id", 32'(rsp_id), 0);
      chk_val("str_rsp_c4_value", golden(700, 1'b0));
      tick();
      chk("str_rsp_c5", 32'(rsp_valid), 0);
      tick();
      chk("str_rsp_c6", 32'(rsp_valid), 1);
      chk("str_rsp_c6_id", 32'(rsp_id), 3);
      chk_val("str_rsp_c6_value", golden(200, 1'b1));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
